wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file.
- Merges results from three sources into the single regfile write port (rd / result / reg_write), one write per cycle:
  - the single-cycle ALU path;
  - the load unit;
  - the multi-cycle mul/div unit.
- Keeps a per-register scoreboard of long-latency destinations and an outstanding-op counter.
- Drives the decode-stage stall signal for RAW/WAW hazards against in-flight long ops.

---
 rtl/wb_arbiter_if.sv | 51 +++++
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: decode issue/hazard, three result sources, regfile write port.
interface wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            issue_valid;
    logic            issue_long;
    logic [4:0]      issue_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            stall;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;

    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;

    logic            div_valid;
    logic            div_ready;
    logic [4:0]      div_rd;
    logic [XLEN-1:0] div_data;

    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            wb_reg_write;
    logic            sb_err;

    // Pipeline / producer side
    modport master (
        output issue_valid, issue_long, issue_rd, dec_rs1, dec_rs2, dec_rd,
        output alu_valid, alu_rd, alu_result,
        output mem_valid, mem_rd, mem_data,
        output div_valid, div_rd, div_data,
        input  stall, mem_ready, div_ready,
        input  wb_rd, wb_result, wb_reg_write, sb_err
    );

    // Arbiter side
    modport slave (
        input  issue_valid, issue_long, issue_rd, dec_rs1, dec_rs2, dec_rd,
        input  alu_valid, alu_rd, alu_result,
        input  mem_valid, mem_rd, mem_data,
        input  div_valid, div_rd, div_data,
        output stall, mem_ready, div_ready,
        output wb_rd, wb_result, wb_reg_write, sb_err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: fixed-priority merge of ALU/load/div results into the regfile
// write port, with a long-latency scoreboard, outstanding-op counter and decode stall.
// Optional macro WB_SB_CHECK_EN enables the sticky sb_err consistency checker.
module wb_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned XLEN            = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NREG  = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic [NREG-1:0]  set_mask;
    logic [NREG-1:0]  clr_mask;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic             mem_acc;
    logic             div_acc;
    logic             long_ack;
    logic             issue_acc;
    logic             inc;
    logic             dec;
    logic             stall_int;

    logic             sel_valid;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;

    logic [4:0]       wb_rd_q;
    logic [XLEN-1:0]  wb_result_q;
    logic             wb_reg_write_q;

    // Fixed priority ALU > mem > div; the ALU can never be back-pressured
    assign bus.mem_ready = !bus.alu_valid;
    assign bus.div_ready = !bus.alu_valid && !bus.mem_valid;
    assign mem_acc       = bus.mem_valid && !bus.alu_valid;
    assign div_acc       = bus.div_valid && !bus.alu_valid && !bus.mem_valid;
    assign long_ack      = mem_acc || div_acc;

    // Hazard stall uses registered busy/count only; clears are not bypassed
    assign stall_int = ((bus.dec_rs1 != 5'd0) && busy[bus.dec_rs1])
                    || ((bus.dec_rs2 != 5'd0) && busy[bus.dec_rs2])
                    || ((bus.dec_rd  != 5'd0) && busy[bus.dec_rd])
                    || (bus.issue_long && (count == CNT_MAX));
    assign bus.stall = stall_int;

    assign issue_acc = bus.issue_valid && bus.issue_long && !stall_int;
    assign inc       = issue_acc && (count != CNT_MAX);
    assign dec       = long_ack && (count != '0);

    // Scoreboard next state: clears first, then sets so a same-register set wins
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_acc && (bus.issue_rd != 5'd0)) set_mask[bus.issue_rd] = 1'b1;
        if (mem_acc) clr_mask[bus.mem_rd] = 1'b1;
        if (div_acc) clr_mask[bus.div_rd] = 1'b1;
        busy_nxt    = (busy & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    // Saturating outstanding counter; simultaneous inc/dec cancels
    always_comb begin
        count_nxt = count;
        case ({inc, dec})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Select the accepted source for the write port
    always_comb begin
        sel_valid = 1'b1;
        sel_rd    = bus.alu_rd;
        sel_data  = bus.alu_result;
        if (bus.alu_valid) begin
            sel_rd   = bus.alu_rd;
            sel_data = bus.alu_result;
        end else if (bus.mem_valid) begin
            sel_rd   = bus.mem_rd;
            sel_data = bus.mem_data;
        end else if (bus.div_valid) begin
            sel_rd   = bus.div_rd;
            sel_data = bus.div_data;
        end else begin
            sel_valid = 1'b0;
        end
    end

    // Scoreboard and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= busy_nxt;
            count <= count_nxt;
        end
    end

    // Registered regfile write port; rd/result hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_q        <= '0;
            wb_result_q    <= '0;
            wb_reg_write_q <= 1'b0;
        end else begin
            wb_reg_write_q <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                wb_rd_q     <= sel_rd;
                wb_result_q <= sel_data;
            end
        end
    end

    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_result    = wb_result_q;
    assign bus.wb_reg_write = wb_reg_write_q;

`ifdef WB_SB_CHECK_EN
    logic err_hit;
    logic sb_err_q;

    assign err_hit = (mem_acc && (bus.mem_rd != 5'd0) && !busy[bus.mem_rd])
                  || (div_acc && (bus.div_rd != 5'd0) && !busy[bus.div_rd])
                  || (long_ack && (count == '0))
                  || (bus.issue_valid && bus.issue_long && (count == CNT_MAX));

    // Sticky consistency error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_err_q <= 1'b0;
        else if (err_hit) sb_err_q <= 1'b1;
    end

    assign bus.sb_err = sb_err_q;
`else
    assign bus.sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (MAX_OUTSTANDING=4, XLEN=32).
module tb_wb_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.MAX_OUTSTANDING(4), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] res);
        chk({tag, "_we"},  32'(bus.wb_reg_write), 32'(we));
        chk({tag, "_rd"},  32'(bus.wb_rd),        32'(rd));
        chk({tag, "_res"}, bus.wb_result,         res);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.issue_rd = 5'd0;
        bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_result = 32'd0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
        bus.div_valid = 1'b0; bus.div_rd = 5'd0; bus.div_data = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = rd;
        tick();
        clr();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk_wb("reset", 1'b0, 5'd0, 32'd0);
        chk("reset_sb_err", 32'(bus.sb_err), 32'd0);
        chk("reset_stall",  32'(bus.stall),  32'd0);
        rst_n = 1'b1;
        tick();

        // ALU path
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_result = 32'hDEADBEEF;
        #1;
        chk("alu_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("alu_div_ready", 32'(bus.div_ready), 32'd0);
        tick();
        chk_wb("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
        bus.alu_rd = 5'd0; bus.alu_result = 32'h11111111;
        tick();
        chk_wb("alu0", 1'b0, 5'd0, 32'h11111111);
        clr();
        tick();
        chk_wb("idle_hold", 1'b0, 5'd0, 32'h11111111);

        // Load RAW/WAW
        bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd7;
        #1;
        chk("issue7_stall", 32'(bus.stall), 32'd0);
        tick();
        clr();
        bus.dec_rs1 = 5'd7; #1;
        chk("raw_rs1", 32'(bus.stall), 32'd1);
        bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd7; #1;
        chk("raw_rs2", 32'(bus.stall), 32'd1);
        bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd7; #1;
        chk("waw_rd", 32'(bus.stall), 32'd1);
        bus.dec_rd = 5'd0; bus.dec_rs1 = 5'd7;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h00001234;
        #1;
        chk("load_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("load_no_bypass", 32'(bus.stall), 32'd1);
        tick();
        bus.mem_valid = 1'b0;
        #1;
        chk("load_stall_drop", 32'(bus.stall), 32'd0);
        chk_wb("load7", 1'b1, 5'd7, 32'h00001234);
        clr();

        // Three-way collision
        issue(5'd10);
        issue(5'd11);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3;  bus.alu_result = 32'hAAAA0003;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data   = 32'hBBBB000A;
        bus.div_valid = 1'b1; bus.div_rd = 5'd11; bus.div_data   = 32'hCCCC000B;
        #1;
        chk("col_mem_ready0", 32'(bus.mem_ready), 32'd0);
        chk("col_div_ready0", 32'(bus.div_ready), 32'd0);
        tick();
        chk_wb("col_alu", 1'b1, 5'd3, 32'hAAAA0003);
        bus.alu_valid = 1'b0; #1;
        chk("col_mem_ready1", 32'(bus.mem_ready), 32'd1);
        chk("col_div_ready1", 32'(bus.div_ready), 32'd0);
        tick();
        chk_wb("col_mem", 1'b1, 5'd10, 32'hBBBB000A);
        bus.mem_valid = 1'b0; #1;
        chk("col_div_ready2", 32'(bus.div_ready), 32'd1);
        tick();
        chk_wb("col_div", 1'b1, 5'd11, 32'hCCCC000B);
        clr();
        bus.dec_rs1 = 5'd10; bus.dec_rs2 = 5'd11; bus.issue_long = 1'b1; #1;
        chk("col_drained", 32'(bus.stall), 32'd0);
        clr();

        // Outstanding limit
        for (int i = 1; i <= 4; i++) issue(5'(i));
        bus.issue_long = 1'b1; #1;
        chk("limit_stall", 32'(bus.stall), 32'd1);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd1; bus.mem_data = 32'h00000055; #1;
        chk("limit_accept_cycle", 32'(bus.stall), 32'd1);
        tick();
        bus.mem_valid = 1'b0; #1;
        chk("limit_drop", 32'(bus.stall), 32'd0);
        chk_wb("limit_mem1", 1'b1, 5'd1, 32'h00000055);
        clr();

        // Same-register set and clear: set wins, count unchanged
        bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd2;
        bus.div_valid = 1'b1; bus.div_rd = 5'd2; bus.div_data = 32'h00000066;
        #1;
        chk("setclr_div_ready", 32'(bus.div_ready), 32'd1);
        chk("setclr_stall",     32'(bus.stall),     32'd0);
        tick();
        clr();
        chk_wb("setclr_div2", 1'b1, 5'd2, 32'h00000066);
        bus.dec_rs1 = 5'd2; #1;
        chk("set_wins", 32'(bus.stall), 32'd1);
        clr();
        issue(5'd5);
        bus.issue_long = 1'b1; #1;
        chk("count_hold", 32'(bus.stall), 32'd1);
        clr();
        for (int i = 2; i <= 5; i++) begin
            bus.div_valid = 1'b1; bus.div_rd = 5'(i); bus.div_data = 32'(i);
            tick();
        end
        clr();
        bus.issue_long = 1'b1; bus.dec_rs1 = 5'd5; #1;
        chk("drained_stall", 32'(bus.stall), 32'd0);
        chk_wb("drain_div5", 1'b1, 5'd5, 32'd5);
        chk("no_sb_err", 32'(bus.sb_err), 32'd0);
        clr();

        // rd=0 long issues count but are not scoreboarded
        for (int i = 0; i < 4; i++) issue(5'd0);
        bus.issue_long = 1'b1; #1;
        chk("rd0_count_stall", 32'(bus.stall), 32'd1);
        clr();

        // Asynchronous reset mid-cycle
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_result = 32'h00000099;
        tick();
        clr();
        chk_wb("pre_reset", 1'b1, 5'd9, 32'h00000099);
        #2 rst_n = 1'b0;
        #1;
        chk_wb("async_reset", 1'b0, 5'd0, 32'd0);
        bus.issue_long = 1'b1; #1;
        chk("reset_count", 32'(bus.stall), 32'd0);
        clr();
        tick();
        rst_n = 1'b1;
        tick();

        // Div handshake to a non-busy register at count 0
        bus.div_valid = 1'b1; bus.div_rd = 5'd9; bus.div_data = 32'h00000077;
        tick();
        clr();
        chk_wb("div9", 1'b1, 5'd9, 32'h00000077);
`ifdef WB_SB_CHECK_EN
        chk("sb_err_set", 32'(bus.sb_err), 32'd1);
        tick();
        tick();
        chk("sb_err_sticky", 32'(bus.sb_err), 32'd1);
        rst_n = 1'b0; #1;
        chk("sb_err_reset", 32'(bus.sb_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`else
        chk("sb_err_tied", 32'(bus.sb_err), 32'd0);
`endif
        // Decrement at zero saturates: four issues reach the limit exactly
        for (int i = 0; i < 3; i++) issue(5'd0);
        bus.issue_long = 1'b1; #1;
        chk("no_underflow_3", 32'(bus.stall), 32'd0);
        clr();
        issue(5'd0);
        bus.issue_long = 1'b1; #1;
        chk("no_underflow_4", 32'(bus.stall), 32'd1);
        clr();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
